fibo_seq_ctrl: RTL

Sequencing controller for the Fibonacci datapath. It owns a parameterised two-register-plus-adder Fibonacci engine and runs it on command. After a `start` pulse it emits a requested number of terms on a valid/ready stream with back-pressure. It signals the end of the run with a one-cycle `done` pulse, flags adder overflow and supports abort. It sits between a host/command interface and downstream consumers such as a display or packer, replacing the free-running generator wherever terms must be produced on demand.

---
 rtl/fibo_seq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fibo_seq_ctrl.sv
// Command-driven Fibonacci term sequencer with valid/ready output, done pulse and sticky overflow.
// Optional FIBO_SEQ_OVF_STOP_EN: end the run on the last term before the adder wraps.
module fibo_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             abort,
  output logic [WIDTH-1:0] term_out,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             term_last,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             b_ovf_q, b_ovf_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;

  logic [WIDTH:0]   sum;
  logic             in_run;
  logic             last_idx;
  logic             last;
  logic             hs;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign in_run   = (state_q == StRun);
  assign last_idx = (idx_q == (cnt_q - CNT_W'(1)));

`ifdef FIBO_SEQ_OVF_STOP_EN
  // b already wrapped, so the current term is the last one that is exact.
  assign last = in_run & (last_idx | b_ovf_q);
`else
  assign last = in_run & last_idx;
`endif

  assign hs = in_run & term_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    b_ovf_d = b_ovf_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ovf_d = 1'b0;
          if (num_terms != '0) begin
            a_d     = '0;
            b_d     = WIDTH'(1);
            idx_d   = '0;
            cnt_d   = num_terms;
            b_ovf_d = 1'b0;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        // Abort wins over a coincident handshake; that term is dropped.
        if (abort) begin
          state_d = StIdle;
        end else if (hs) begin
          if (last) begin
            state_d = StDone;
          end else begin
            a_d     = b_q;
            b_d     = sum[WIDTH-1:0];
            b_ovf_d = sum[WIDTH];
            ovf_d   = ovf_q | sum[WIDTH];
            idx_d   = idx_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      b_ovf_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      b_ovf_q <= b_ovf_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign term_out   = a_q;
  assign term_valid = in_run;
  assign term_last  = last;
  assign busy       = in_run;
  assign done       = (state_q == StDone);
  assign ovf        = ovf_q;

endmodule
